weight_tile_scheduler: RTL
==========================

# weight_tile_scheduler

Sequences the weight memory controller across the tile loop of one convolution layer. For each (output-tile, input-tile) pair it arms the weight loader with the correct start address and waits a fixed load latency. It then launches the Tm×Tn compute array and waits for completion. Between tiles it drops the loader's `state` so the loader re-arms. It sits between the layer-level top controller and the weight memory controller / PE array.

## Interface
Parameters:
- `Tn`, `` `Tn `` (4): input channels per tile; weight rows consumed per tile.
- `LOAD_LAT`, 8: cycles `weight_state` is held high before compute starts (≥ Tn + 4).
- `CNT_W`, 6: width of tile-count inputs.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle layer start; honoured only in IDLE.
- `base_addr` in 10: weight memory row of the layer's first tile.
- `n_tiles` in CNT_W: input-channel tiles per output tile.
- `m_tiles` in CNT_W: output-channel tiles in the layer.
- `compute_done` in 1: one-cycle pulse from the PE array.
- `weight_state` out 1: drives the weight controller `state`.
- `weight_mem_init_addr` out 10: drives the weight controller init address.
- `compute_start` out 1: one-cycle pulse to the PE array.
- `first_in_tile` out 1: high while the current in-tile index is 0 (accumulator clear).
- `last_in_tile` out 1: high while the in-tile index is n_tiles−1 (write-back).
- `in_idx` out CNT_W, `out_idx` out CNT_W: current tile indices.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse at layer end.
- `abort` in 1: present only with `WSCHED_ABORT_EN`.

## Operation
- States: IDLE, LOAD, COMPUTE, RELEASE, FIN.
- IDLE:
  - On `start`, latch `base_addr`, `n_tiles`, `m_tiles`; clear indices; set address offset to 0.
  - If either count is 0, go to FIN; otherwise go to LOAD.
  - `start` outside IDLE is ignored.
- LOAD:
  - `weight_state`=1 and `weight_mem_init_addr` = base + offset (mod 1024), stable for the whole state.
  - A load counter runs 0..LOAD_LAT−1; at LOAD_LAT−1 go to COMPUTE.
- COMPUTE:
  - `weight_state` stays 1.
  - `compute_start` pulses on the first COMPUTE cycle only.
  - Wait for `compute_done`, then go to RELEASE.
  - `compute_done` in any other state is ignored.
  - `compute_done` coincident with the `compute_start` cycle counts as completion.
- RELEASE (exactly 1 cycle): `weight_state`=0.
  - offset += Tn (10-bit wrap, no multiplier).
  - If in_idx < n−1: in_idx++ and go to LOAD.
  - Else if out_idx < m−1: in_idx=0, out_idx++, go to LOAD.
  - Else go to FIN.
- FIN (1 cycle): `done`=1, then IDLE. Indices hold their last values until the next start.
- Tile order: in_idx is the inner loop. Tile k, counted in order, uses address base + k·Tn.
- Reset values:
  - State IDLE.
  - All outputs 0, indices 0.
  - `weight_mem_init_addr` = 0.
- `rst` in any state returns to IDLE on the next edge and overrides everything else.

## Timing
- `start` at cycle 0 → LOAD and `weight_state`=1 from cycle 1.
- `compute_start` at cycle 1+LOAD_LAT.
- `compute_done` at cycle t → RELEASE at t+1 (`weight_state`=0), next LOAD at t+2.
- After the final tile's `compute_done` at t: `done` at t+2, `busy` low from t+3.
- Zero-count start at cycle 0: `done` at cycle 2, no `weight_state` assertion.
- `first_in_tile`/`last_in_tile` are combinational from registered indices, valid from LOAD through RELEASE.

## Configuration
- `WSCHED_ABORT_EN` defined:
  - `abort` port exists. `abort`=1 in any non-IDLE state forces IDLE on the next edge.
  - `weight_state`=0, no `done` pulse, indices hold.
  - Abort has priority over `compute_done`.
- `WSCHED_ABORT_EN` undefined: no `abort` port; a layer always runs to FIN.

## Test plan
- Reset:
  - Stimulus: hold `rst` 3 cycles mid-COMPUTE.
  - Response: next cycle all outputs 0, `busy`=0, and a `start` is accepted immediately after.
- Single tile:
  - Stimulus: base=0x010, n=1, m=1, LOAD_LAT=8; `compute_done` 5 cycles after `compute_start`.
  - Response: addr 0x010; `compute_start` at cycle 9; `first_in_tile`=`last_in_tile`=1; `done` at cycle 16.
- Loop order:
  - Stimulus: base=0, n=3, m=2.
  - Response: addresses 0,4,8,12,16,20; (out,in) = (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); `weight_state` low exactly one cycle between tiles; one `done`.
- Wrap:
  - Stimulus: base=0x3FC, n=2, m=1.
  - Response: addresses 0x3FC then 0x000.
- Zero count / ignored start:
  - Stimulus: n=0, m=5.
  - Response: `done` at cycle 2, `weight_state` never high.
  - Stimulus: `start` pulsed while busy.
  - Response: no effect on the current layer.
- Abort (`WSCHED_ABORT_EN`):
  - Stimulus: `abort` during the second tile's LOAD.
  - Response: IDLE next cycle, `weight_state`=0, no `done`; a new `start` runs the full layer correctly.

Source files
------------

// File: rtl/weight_tile_scheduler.sv
// weight_tile_scheduler
//   Walks the (output-tile, input-tile) loop of one convolution layer. For each
//   tile it arms the weight loader at base + k*Tn, holds it for LOAD_LAT cycles,
//   fires the PE array and waits for completion, then drops the loader state
//   for one cycle so it re-arms for the next tile.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   start                : one-cycle layer start (honoured only in IDLE)
//   base_addr            : weight row of the layer's first tile
//   n_tiles, m_tiles     : input-tiles per output tile, output tiles per layer
//   compute_done         : completion pulse from the PE array
//   abort                : cancel the running layer (WSCHED_ABORT_EN only)
//   weight_state         : weight controller state (arm/hold)
//   weight_mem_init_addr : weight controller start row
//   compute_start        : one-cycle launch pulse to the PE array
//   first_in_tile        : in-tile index is 0 (accumulator clear)
//   last_in_tile         : in-tile index is n_tiles-1 (write-back)
//   in_idx, out_idx      : current tile indices
//   busy, done           : layer in progress / one-cycle end-of-layer pulse
//
// Build option: define WSCHED_ABORT_EN to add the abort input.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start
// S_LOAD    | loader armed, LOAD_LAT-cycle down-counter running
// S_COMPUTE | loader held, PE array running until compute_done
// S_RELEASE | loader state dropped one cycle, advance tile indices
// S_FIN     | done pulse, back to IDLE
module weight_tile_scheduler #(
  parameter int Tn       = 4,
  parameter int LOAD_LAT = 8,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [9:0]       base_addr,
  input  logic [CNT_W-1:0] n_tiles,
  input  logic [CNT_W-1:0] m_tiles,
  input  logic             compute_done,
`ifdef WSCHED_ABORT_EN
  input  logic             abort,
`endif
  output logic             weight_state,
  output logic [9:0]       weight_mem_init_addr,
  output logic             compute_start,
  output logic             first_in_tile,
  output logic             last_in_tile,
  output logic [CNT_W-1:0] in_idx,
  output logic [CNT_W-1:0] out_idx,
  output logic             busy,
  output logic             done
);

  localparam int LCW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_RELEASE, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [LCW-1:0]   load_cnt_q, load_cnt_d;
  logic [9:0]       base_q, base_d;
  logic [9:0]       offset_q, offset_d;
  logic [9:0]       addr_q, addr_d;
  logic [CNT_W-1:0] n_q, n_d, m_q, m_d;
  logic [CNT_W-1:0] in_q, in_d, out_q, out_d;
  logic             empty_q, empty_d;
  logic             ws_q, ws_d, cs_q, cs_d, busy_q, busy_d, done_q, done_d;
  logic             abort_req, in_last, out_last, tile_phase;

`ifdef WSCHED_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign in_last  = (in_q == n_q - CNT_W'(1));
  assign out_last = (out_q == m_q - CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    base_d     = base_q;
    offset_d   = offset_q;
    addr_d     = addr_q;
    n_d        = n_q;
    m_d        = m_q;
    in_d       = in_q;
    out_d      = out_q;
    empty_d    = empty_q;
    cs_d       = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          n_d        = n_tiles;
          m_d        = m_tiles;
          in_d       = '0;
          out_d      = '0;
          offset_d   = '0;
          empty_d    = (n_tiles == '0) || (m_tiles == '0);
          // An empty layer still passes through RELEASE so its done pulse
          // lands two cycles after start, like the tail of a normal layer.
          if ((n_tiles == '0) || (m_tiles == '0)) begin
            state_d = S_RELEASE;
          end else begin
            state_d    = S_LOAD;
            load_cnt_d = LCW'(LOAD_LAT - 1);
            addr_d     = base_addr;
          end
        end
      end
      S_LOAD: begin
        if (load_cnt_q == '0) begin
          state_d = S_COMPUTE;
          cs_d    = 1'b1;
        end else begin
          load_cnt_d = load_cnt_q - LCW'(1);
        end
      end
      S_COMPUTE: begin
        if (compute_done) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        offset_d = offset_q + 10'(Tn);
        if (empty_q || (in_last && out_last)) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          if (!in_last) begin
            in_d = in_q + CNT_W'(1);
          end else begin
            in_d  = '0;
            out_d = out_q + CNT_W'(1);
          end
          state_d    = S_LOAD;
          load_cnt_d = LCW'(LOAD_LAT - 1);
          addr_d     = base_q + offset_q + 10'(Tn);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_req && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cs_d    = 1'b0;
      done_d  = 1'b0;
      in_d    = in_q;
      out_d   = out_q;
    end

    // Outputs are registered from the next state so they align with it.
    ws_d   = (state_d == S_LOAD) || (state_d == S_COMPUTE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      base_q     <= '0;
      offset_q   <= '0;
      addr_q     <= '0;
      n_q        <= '0;
      m_q        <= '0;
      in_q       <= '0;
      out_q      <= '0;
      empty_q    <= 1'b0;
      ws_q       <= 1'b0;
      cs_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      base_q     <= base_d;
      offset_q   <= offset_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      m_q        <= m_d;
      in_q       <= in_d;
      out_q      <= out_d;
      empty_q    <= empty_d;
      ws_q       <= ws_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Tile flags only mean something while a real tile is in flight.
  assign tile_phase = !empty_q &&
                      ((state_q == S_LOAD) || (state_q == S_COMPUTE) || (state_q == S_RELEASE));

  assign weight_state         = ws_q;
  assign weight_mem_init_addr = addr_q;
  assign compute_start        = cs_q;
  assign first_in_tile        = tile_phase && (in_q == '0);
  assign last_in_tile         = tile_phase && in_last;
  assign in_idx               = in_q;
  assign out_idx              = out_q;
  assign busy                 = busy_q;
  assign done                 = done_q;

endmodule
